// File: rtl/neuron_sequencer.sv
// neuron_sequencer: walks one MAC core through clear, operand fetch, drain and result capture.
// Build option NEURON_SEQ_BIAS_EN adds a bias port and one extra operand cycle (weight=bias, input=1).
module neuron_sequencer #(
  parameter int N        = 8,
  parameter int N_INPUTS = 16,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] x_base,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] x_addr,
  input  logic [N-1:0]      w_rdata,
  input  logic [N-1:0]      x_rdata,
  output logic [N-1:0]      mac_weight,
  output logic [N-1:0]      mac_in,
  output logic              mac_reset,
  output logic              mac_forget,
  output logic              mac_oe,
  input  logic [N-1:0]      mac_out,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [N-1:0]      result_data,
`ifdef NEURON_SEQ_BIAS_EN
  input  logic [N-1:0]      bias,
`endif
  output logic [2:0]        dbg_state_o
);

  // Result handshake: result_valid stays high with result_data frozen until a cycle in which
  // result_ready is also high; that cycle completes the transfer and the FSM returns to IDLE.

  localparam int CW = $clog2(N_INPUTS + 1);
  localparam logic [CW-1:0] LAST_RD = CW'(N_INPUTS - 1);
`ifdef NEURON_SEQ_BIAS_EN
  localparam logic [CW-1:0] LAST_FETCH = CW'(N_INPUTS);
`else
  localparam logic [CW-1:0] LAST_FETCH = CW'(N_INPUTS - 1);
`endif

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, CAPTURE, VALID} state_t;

  state_t            state_q;
  logic [CW-1:0]     idx_q;
  logic              drain_q;
  logic              dv_q;
  logic [ADDR_W-1:0] w_base_q, x_base_q;
  logic              mem_ren_q;
  logic [ADDR_W-1:0] w_addr_q, x_addr_q;
  logic              mac_reset_q, mac_oe_q;
  logic              busy_q, result_valid_q;
  logic [N-1:0]      result_data_q;
`ifdef NEURON_SEQ_BIAS_EN
  logic              bv_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      drain_q        <= 1'b0;
      dv_q           <= 1'b0;
      w_base_q       <= '0;
      x_base_q       <= '0;
      mem_ren_q      <= 1'b0;
      w_addr_q       <= '0;
      x_addr_q       <= '0;
      mac_reset_q    <= 1'b0;
      mac_oe_q       <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
`ifdef NEURON_SEQ_BIAS_EN
      bv_q           <= 1'b0;
`endif
    end else begin
      dv_q        <= mem_ren_q;
      mac_reset_q <= 1'b0;
      mac_oe_q    <= 1'b0;
`ifdef NEURON_SEQ_BIAS_EN
      bv_q        <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            w_base_q    <= w_base;
            x_base_q    <= x_base;
            mac_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= CLEAR;
          end
        end
        CLEAR: begin
          idx_q     <= '0;
          mem_ren_q <= 1'b1;
          w_addr_q  <= w_base_q;
          x_addr_q  <= x_base_q;
          state_q   <= FETCH;
        end
        FETCH: begin
          if (idx_q == LAST_FETCH) begin
            mem_ren_q <= 1'b0;
            drain_q   <= 1'b0;
            state_q   <= DRAIN;
`ifdef NEURON_SEQ_BIAS_EN
            bv_q      <= 1'b1;
`endif
          end else begin
            idx_q <= idx_q + CW'(1);
            // Only reachable with the bias cycle: stop reading, hold the addresses.
            if (idx_q == LAST_RD) begin
              mem_ren_q <= 1'b0;
            end else begin
              w_addr_q <= w_addr_q + ADDR_W'(1);
              x_addr_q <= x_addr_q + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_q) begin
            mac_oe_q <= 1'b1;
            state_q  <= CAPTURE;
          end else begin
            drain_q <= 1'b1;
          end
        end
        CAPTURE: begin
          result_data_q  <= mac_out;
          result_valid_q <= 1'b1;
          state_q        <= VALID;
        end
        VALID: begin
          if (result_ready) begin
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operands are gated by the data-valid flag so non-read cycles add a zero product.
  always_comb begin
    mac_weight = '0;
    mac_in     = '0;
    if (dv_q) begin
      mac_weight = w_rdata;
      mac_in     = x_rdata;
    end
`ifdef NEURON_SEQ_BIAS_EN
    else if (bv_q) begin
      mac_weight = bias;
      mac_in     = N'(1);
    end
`endif
  end

  assign mem_ren      = mem_ren_q;
  assign w_addr       = w_addr_q;
  assign x_addr       = x_addr_q;
  assign mac_reset    = mac_reset_q;
  assign mac_forget   = 1'b0;
  assign mac_oe       = mac_oe_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// tb_neuron_sequencer: randomized runs of neuron_sequencer against memory/MAC stand-ins and a
// dot-product reference model; a negedge monitor pops expected addresses, cycles and results.
`timescale 1ns/1ps
module tb_neuron_sequencer;
  localparam int N  = 8;
  localparam int NI = 8;
  localparam int AW = 8;
`ifdef NEURON_SEQ_BIAS_EN
  localparam int B = 1;
`else
  localparam int B = 0;
`endif

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, result_ready = 1'b0;
  logic [AW-1:0] w_base = '0, x_base = '0, w_addr, x_addr;
  logic          mem_ren, mac_reset, mac_forget, mac_oe, busy, result_valid;
  logic [N-1:0]  w_rdata = '0, x_rdata = '0, mac_weight, mac_in, mac_out, result_data;
  logic [2:0]    dbg_state;
`ifdef NEURON_SEQ_BIAS_EN
  logic [N-1:0]  bias_v = '0;
`endif

  logic [7:0] w_mem [256];
  logic [7:0] x_mem [256];
  int  cyc = 0, n_chk = 0, n_fail = 0;
  bit  mon_en = 1'b0;

  logic [15:0] exp_addr_q [$];
  logic [7:0]  exp_res_q [$];
  int          exp_clr_q [$];
  int          exp_oe_q [$];
  int          exp_val_q [$];

  neuron_sequencer #(.N(N), .N_INPUTS(NI), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .w_base(w_base), .x_base(x_base),
    .mem_ren(mem_ren), .w_addr(w_addr), .x_addr(x_addr), .w_rdata(w_rdata), .x_rdata(x_rdata),
    .mac_weight(mac_weight), .mac_in(mac_in), .mac_reset(mac_reset), .mac_forget(mac_forget),
    .mac_oe(mac_oe), .mac_out(mac_out), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result_data(result_data),
`ifdef NEURON_SEQ_BIAS_EN
    .bias(bias_v),
`endif
    .dbg_state_o(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sat(input longint v);
    if (v > 127) return 8'h7f;
    if (v < -128) return 8'h80;
    return v[7:0];
  endfunction

  // synchronous-read memories
  always @(posedge clk) begin
    if (mem_ren === 1'b1) begin
      w_rdata <= w_mem[w_addr];
      x_rdata <= x_mem[x_addr];
    end
  end

  // MAC core stand-in: operand registers, accumulator, saturating quantizer
  logic signed [7:0] w_r = '0, x_r = '0;
  longint acc = 0;
  always @(posedge clk) begin
    if (mac_reset === 1'b1) begin
      w_r <= '0; x_r <= '0; acc <= 0;
    end else begin
      w_r <= mac_weight; x_r <= mac_in;
      acc <= acc + longint'(w_r) * longint'(x_r);
    end
  end
  assign mac_out = (mac_oe === 1'b1) ? sat(acc) : 8'h00;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 256; i++) begin
      w_mem[i] = v; x_mem[i] = v;
    end
  endtask

  task automatic fill_rand();
    int r;
    for (int i = 0; i < 256; i++) begin
      r = int'($urandom_range(0, 6)) - 3; w_mem[i] = 8'(r);
      r = int'($urandom_range(0, 6)) - 3; x_mem[i] = 8'(r);
    end
  endtask

  // driver: compute the neuron's expected behaviour, then pulse start
  task automatic issue(input logic [7:0] wb, input logic [7:0] xb, input bit abort);
    longint s;
    logic [7:0] wa, xa;
    s = 0;
    for (int i = 0; i < (abort ? 4 : NI); i++) begin
      wa = wb + 8'(i);
      xa = xb + 8'(i);
      exp_addr_q.push_back({wa, xa});
      s += longint'($signed(w_mem[wa])) * longint'($signed(x_mem[xa]));
    end
`ifdef NEURON_SEQ_BIAS_EN
    s += longint'($signed(bias_v));
`endif
    exp_clr_q.push_back(cyc + 1);
    if (!abort) begin
      exp_res_q.push_back(sat(s));
      exp_oe_q.push_back(cyc + NI + 4 + B);
      exp_val_q.push_back(cyc + NI + 5 + B);
    end
    w_base = wb; x_base = xb; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish(input int hold, input bit poke_start, input bit start_on_hs);
    for (int k = 0; k < 200 && !result_valid; k++) step();
    if (!result_valid) chk("valid_timeout", 0, 1);
    for (int j = 0; j < hold; j++) begin
      if (poke_start && j == 2) start = 1'b1;
      step();
      start = 1'b0;
      chk("busy_hold", longint'(busy), 1);
    end
    result_ready = 1'b1; start = start_on_hs;
    step();
    result_ready = 1'b0; start = 1'b0;
    chk("busy_after_hs", longint'(busy), 0);
    step();
    chk("idle_after_hs", longint'({busy, dbg_state}), 0);
  endtask

  // monitor / scoreboard
  logic [7:0] oe_sample = '0, held = '0;
  bit seen = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (mac_reset) begin
        if (exp_clr_q.size() == 0) chk("clr_unexpected", 1, 0);
        else chk("clr_cycle", longint'(cyc), longint'(exp_clr_q.pop_front()));
      end
      if (mem_ren) begin
        if (exp_addr_q.size() == 0) chk("addr_unexpected", 1, 0);
        else chk("addr", longint'({w_addr, x_addr}), longint'(exp_addr_q.pop_front()));
      end
      if (mac_oe) begin
        oe_sample = mac_out;
        if (exp_oe_q.size() == 0) chk("oe_unexpected", 1, 0);
        else chk("oe_cycle", longint'(cyc), longint'(exp_oe_q.pop_front()));
      end
      if (result_valid) begin
        if (!seen) begin
          seen = 1'b1;
          held = result_data;
          if (exp_val_q.size() == 0) chk("valid_unexpected", 1, 0);
          else chk("valid_cycle", longint'(cyc), longint'(exp_val_q.pop_front()));
        end else begin
          chk("data_stable", longint'(result_data), longint'(held));
        end
        if (result_ready) begin
          seen = 1'b0;
          chk("data_vs_oe_sample", longint'(result_data), longint'(oe_sample));
          if (exp_res_q.size() == 0) chk("result_unexpected", 1, 0);
          else chk("result", longint'(result_data), longint'(exp_res_q.pop_front()));
        end
      end
    end
  end

  initial begin
    fill_const(8'd127);
    repeat (2) step();
    reset = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("reset_idle", longint'({busy, result_valid, result_data, mem_ren, w_addr, x_addr,
          mac_weight, mac_in, mac_reset, mac_oe, mac_forget, dbg_state}), 0);
    end

    // all-127 operands, bases 0: saturated result
    issue(8'd0, 8'd0, 1'b0);
    finish(0, 1'b0, 1'b0);

    // address wrap of the weight base
    fill_rand();
    issue(8'd250, 8'h10, 1'b0);
    finish(1, 1'b0, 1'b0);

    // backpressure with start pulsed in VALID, and start during the handshake
    fill_rand();
    issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    finish(5, 1'b1, 1'b1);

    // reset at fetch index 3, then a fresh run on new data
    fill_rand();
    issue(8'd3, 8'd7, 1'b1);
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_idle", longint'({dbg_state, busy, mem_ren}), 0);
    fill_rand();
    issue(8'd5, 8'd9, 1'b0);
    finish(0, 1'b0, 1'b0);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      fill_rand();
`ifdef NEURON_SEQ_BIAS_EN
      bias_v = 8'($urandom_range(0, 255));
`endif
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
      finish(int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    repeat (3) step();
    chk("addr_q_empty", longint'(exp_addr_q.size()), 0);
    chk("res_q_empty", longint'(exp_res_q.size()), 0);
    chk("oe_q_empty", longint'(exp_oe_q.size()), 0);
    chk("val_q_empty", longint'(exp_val_q.size()), 0);
    chk("clr_q_empty", longint'(exp_clr_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
